// File: rtl/mem_ctrl_pkg.sv
// mem_ctrl_pkg: state encodings, byte-count codes and RAM widths shared by mem_ctrl.
package mem_ctrl_pkg;
    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;
    localparam int RAM_DW = 8;
    localparam logic [2:0] BC_BYTE = 3'd1;
    localparam logic [2:0] BC_HALF = 3'd2;
    localparam logic [2:0] BC_WORD = 3'd4;
    typedef enum logic [2:0] {IDLE, IF_RD, MEM_RD, MEM_WR, DONE} state_t;
    function automatic logic cnt_ok(input logic [2:0] n);
        return n == BC_BYTE || n == BC_HALF || n == BC_WORD;
    endfunction
    function automatic logic misaligned(input logic [2:0] n, input logic [1:0] a);
        return (n == BC_HALF && a[0]) || (n == BC_WORD && a != 2'b00);
    endfunction
endpackage

// File: rtl/mem_ctrl.sv
// mem_ctrl: arbitrates instruction fetches and MEM-stage loads/stores onto a byte-wide RAM.
// Define MEM_CTRL_ALIGN_CHK_EN to reject misaligned half/word MEM accesses via mem_misalign.
module mem_ctrl
    import mem_ctrl_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic [DATA_W-1:0] if_rdata,
    output logic              if_done,
    input  logic              re_m,
    input  logic              we_m,
    input  logic [2:0]        rvalid_bit,
    input  logic [2:0]        wvalid_bit,
    input  logic [ADDR_W-1:0] raddr_m,
    input  logic [ADDR_W-1:0] waddr_m,
    input  logic [DATA_W-1:0] wdata_m,
    output logic [DATA_W-1:0] rdata_m,
    output logic              mem_done,
    output logic              stall_req,
`ifdef MEM_CTRL_ALIGN_CHK_EN
    output logic              mem_misalign,
`endif
    output logic [ADDR_W-1:0] ram_addr,
    output logic              ram_wr,
    output logic [RAM_DW-1:0] ram_dout,
    input  logic [RAM_DW-1:0] ram_din
);
    state_t            state, state_n;
    logic [2:0]        k, n_q, g_cnt;
    logic [ADDR_W-1:0] base, g_addr;
    logic              is_mem, mem_req, busy, g_bad;
    logic [1:0]        lane;

    assign mem_req = re_m | we_m;
    assign g_cnt   = we_m ? wvalid_bit : rvalid_bit;
    assign g_addr  = we_m ? waddr_m : raddr_m;
    assign busy    = state == IF_RD || state == MEM_RD || state == MEM_WR;
    // read data arrives one cycle after its address, so byte k-1 lands while k is driven
    assign lane    = k[1:0] - 2'd1;

`ifdef MEM_CTRL_ALIGN_CHK_EN
    logic mis_q;
    assign g_bad        = !cnt_ok(g_cnt) || misaligned(g_cnt, g_addr[1:0]);
    assign mem_misalign = state == DONE && is_mem && mis_q;
    always_ff @(posedge clk) begin
        if (!rst)
            mis_q <= 1'b0;
        else if (state == IDLE && mem_req)
            mis_q <= misaligned(g_cnt, g_addr[1:0]);
    end
`else
    assign g_bad = !cnt_ok(g_cnt);
`endif

    always_comb begin
        state_n = state;
        case (state)
            IDLE:         state_n = mem_req ? (g_bad ? DONE : (we_m ? MEM_WR : MEM_RD)) :
                                    (if_req ? IF_RD : IDLE);
            IF_RD, MEM_RD: state_n = k == n_q ? DONE : state;
            MEM_WR:       state_n = k == n_q - 3'd1 ? DONE : MEM_WR;
            default:      state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state    <= IDLE;
            k        <= '0;
            n_q      <= '0;
            base     <= '0;
            is_mem   <= 1'b0;
            if_rdata <= '0;
            rdata_m  <= '0;
        end else begin
            state <= state_n;
            if (state == IDLE) begin
                k <= '0;
                if (mem_req) begin
                    is_mem  <= 1'b1;
                    n_q     <= g_cnt;
                    base    <= g_addr;
                    rdata_m <= '0;
                end else if (if_req) begin
                    is_mem   <= 1'b0;
                    n_q      <= BC_WORD;
                    base     <= if_addr;
                    if_rdata <= '0;
                end
            end else if (busy) begin
                k <= k + 3'd1;
                if (state == IF_RD && k != 3'd0)
                    if_rdata[{lane, 3'b000} +: RAM_DW] <= ram_din;
                if (state == MEM_RD && k != 3'd0)
                    rdata_m[{lane, 3'b000} +: RAM_DW] <= ram_din;
            end
        end
    end

    assign ram_wr    = state == MEM_WR;
    assign ram_addr  = (busy && k < n_q) ? base + ADDR_W'(k) : '0;
    assign ram_dout  = ram_wr ? wdata_m[{k[1:0], 3'b000} +: RAM_DW] : '0;
    assign if_done   = state == DONE && !is_mem;
    assign mem_done  = state == DONE && is_mem;
    assign stall_req = rst && (busy || (state == IDLE && mem_req));
endmodule

// File: tb/tb_mem_ctrl.sv
// tb_mem_ctrl: randomized self-checking bench for mem_ctrl against a byte-array reference model.
module tb_mem_ctrl;
`ifdef MEM_CTRL_ALIGN_CHK_EN
    localparam bit ALIGN = 1'b1;
`else
    localparam bit ALIGN = 1'b0;
`endif
    logic        clk = 1'b0, rst = 1'b0;
    logic        if_req = 1'b0, re_m = 1'b0, we_m = 1'b0;
    logic [31:0] if_addr = '0, raddr_m = '0, waddr_m = '0, wdata_m = '0;
    logic [2:0]  rvalid_bit = '0, wvalid_bit = '0;
    logic [31:0] if_rdata, rdata_m, ram_addr;
    logic        if_done, mem_done, stall_req, ram_wr, mis_sig;
    logic [7:0]  ram_dout, ram_din;
    int n_chk = 0, n_fail = 0;

    mem_ctrl dut (
        .clk(clk), .rst(rst), .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata),
        .if_done(if_done), .re_m(re_m), .we_m(we_m), .rvalid_bit(rvalid_bit),
        .wvalid_bit(wvalid_bit), .raddr_m(raddr_m), .waddr_m(waddr_m), .wdata_m(wdata_m),
        .rdata_m(rdata_m), .mem_done(mem_done), .stall_req(stall_req),
`ifdef MEM_CTRL_ALIGN_CHK_EN
        .mem_misalign(mis_sig),
`endif
        .ram_addr(ram_addr), .ram_wr(ram_wr), .ram_dout(ram_dout), .ram_din(ram_din)
    );
`ifndef MEM_CTRL_ALIGN_CHK_EN
    assign mis_sig = 1'b0;
`endif

    always #5 clk = ~clk;

    // byte RAM with full-address tags so aliasing in the small array cannot hide address faults
    logic [7:0]    ram [0:1023];
    logic [31:0]   tag [0:1023];
    logic [1023:0] vld = '0;
    int            wr_cnt = 0;
    logic          pl_en = 1'b0;
    logic [31:0]   pl_addr = '0;
    logic [7:0]    pl_data = '0;
    always @(posedge clk) begin
        if (ram_wr) begin
            ram[ram_addr[9:0]] <= ram_dout;
            tag[ram_addr[9:0]] <= ram_addr;
            vld[ram_addr[9:0]] <= 1'b1;
            wr_cnt <= wr_cnt + 1;
        end
        if (pl_en) begin
            ram[pl_addr[9:0]] <= pl_data;
            tag[pl_addr[9:0]] <= pl_addr;
            vld[pl_addr[9:0]] <= 1'b1;
        end
        ram_din <= (vld[ram_addr[9:0]] && tag[ram_addr[9:0]] == ram_addr) ? ram[ram_addr[9:0]] : 8'h00;
    end

    function automatic logic [7:0] ram_at(input logic [31:0] a);
        return (vld[a[9:0]] && tag[a[9:0]] == a) ? ram[a[9:0]] : 8'h00;
    endfunction

    logic [7:0] ref_mem [logic [31:0]];
    function automatic logic [7:0] rb(input logic [31:0] a);
        return ref_mem.exists(a) ? ref_mem[a] : 8'h00;
    endfunction
    function automatic bit m_valid(input logic [2:0] n);
        return n == 3'd1 || n == 3'd2 || n == 3'd4;
    endfunction
    function automatic bit m_mis(input logic [2:0] n, input logic [31:0] a);
        return ALIGN && m_valid(n) && n > 3'd1 && (a % {29'd0, n}) != 0;
    endfunction
    function automatic int exp_lat(input logic wr, input logic [2:0] n, input logic [31:0] a);
        if (!m_valid(n) || m_mis(n, a)) return 1;
        return wr ? int'(n) + 1 : int'(n) + 2;
    endfunction
    function automatic logic [31:0] le_bytes(input int n, input logic [31:0] a);
        logic [31:0] v = '0;
        for (int i = 0; i < n; i++) v[8*i +: 8] = rb(a + 32'(i));
        return v;
    endfunction
    function automatic logic [31:0] exp_rd(input logic [2:0] n, input logic [31:0] a);
        return (!m_valid(n) || m_mis(n, a)) ? 32'h0 : le_bytes(int'(n), a);
    endfunction
    function automatic logic [31:0] ram_word(input logic [31:0] a);
        return {ram_at(a + 32'd3), ram_at(a + 32'd2), ram_at(a + 32'd1), ram_at(a)};
    endfunction
    task automatic model_write(input logic [2:0] n, input logic [31:0] a, input logic [31:0] wd);
        if (m_valid(n) && !m_mis(n, a))
            for (int i = 0; i < int'(n); i++) ref_mem[a + 32'(i)] = wd[8*i +: 8];
    endtask

    task automatic preload(input logic [31:0] a, input logic [7:0] b);
        @(negedge clk);
        pl_en = 1'b1; pl_addr = a; pl_data = b;
        ref_mem[a] = b;
        @(posedge clk); #1;
        pl_en = 1'b0;
    endtask

    task automatic do_mem(input logic wr, input logic rd, input logic [2:0] n, input logic [31:0] a,
                          input logic [31:0] wd, output int lat, output logic [31:0] d,
                          output logic mis, output logic stall_bad);
        @(negedge clk);
        we_m = wr; re_m = rd; wvalid_bit = n; rvalid_bit = n;
        waddr_m = a; raddr_m = a; wdata_m = wd;
        lat = 0; d = '0; mis = 1'b0;
        #1 stall_bad = (stall_req !== 1'b1);
        while (lat < 60) begin
            @(posedge clk); #1;
            lat++;
            if (mem_done === 1'b1) begin
                d = rdata_m; mis = mis_sig;
                stall_bad |= (stall_req !== 1'b0);
                break;
            end
            stall_bad |= (stall_req !== 1'b1);
        end
        we_m = 1'b0; re_m = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic do_if(input logic [31:0] a, output int lat, output logic [31:0] d);
        @(negedge clk);
        if_req = 1'b1; if_addr = a; lat = 0; d = '0;
        while (lat < 60) begin
            @(posedge clk); #1;
            lat++;
            if (if_done === 1'b1) begin
                d = if_rdata;
                break;
            end
        end
        if_req = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_reset;
        we_m = 1'b1; wvalid_bit = 3'd4;
        repeat (3) @(posedge clk);
        #1;
        n_chk++;
        if ({ram_wr, ram_addr, ram_dout, if_rdata, rdata_m, if_done, mem_done, stall_req, mis_sig} !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs: got wr=%b addr=%h dout=%h ifr=%h rd=%h ifd=%b md=%b st=%b mis=%b required all zero",
                     ram_wr, ram_addr, ram_dout, if_rdata, rdata_m, if_done, mem_done, stall_req, mis_sig);
        end
        we_m = 1'b0;
        @(negedge clk); rst = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_sw;
        int lat, w0; logic [31:0] d; logic mis, sb;
        w0 = wr_cnt;
        do_mem(1'b1, 1'b0, 3'd4, 32'h100, 32'h11223344, lat, d, mis, sb);
        model_write(3'd4, 32'h100, 32'h11223344);
        n_chk++; if (lat !== 5) begin n_fail++; $display("FAIL sw_latency: got %0d required 5", lat); end
        n_chk++; if (ram_word(32'h100) !== le_bytes(4, 32'h100)) begin n_fail++; $display("FAIL sw_bytes: got %h required %h", ram_word(32'h100), le_bytes(4, 32'h100)); end
        n_chk++; if (wr_cnt - w0 !== 4) begin n_fail++; $display("FAIL sw_write_count: got %0d required 4", wr_cnt - w0); end
        n_chk++; if (sb !== 1'b0) begin n_fail++; $display("FAIL sw_stall: stall_req profile wrong"); end
    endtask

    task automatic test_lh;
        int lat; logic [31:0] d, e; logic mis, sb;
        preload(32'h102, 8'h80);
        preload(32'h103, 8'hFF);
        e = exp_rd(3'd2, 32'h102);
        do_mem(1'b0, 1'b1, 3'd2, 32'h102, 32'h0, lat, d, mis, sb);
        n_chk++; if (lat !== 4) begin n_fail++; $display("FAIL lh_latency: got %0d required 4", lat); end
        n_chk++; if (d !== e) begin n_fail++; $display("FAIL lh_data: got %h required %h", d, e); end
        n_chk++; if (sb !== 1'b0) begin n_fail++; $display("FAIL lh_stall: stall_req profile wrong"); end
    endtask

    task automatic test_arbitration;
        int c, md, id, md_exp; logic [31:0] rdm, rdi, em, ei; logic sb;
        for (int i = 0; i < 4; i++) preload(32'h110 + 32'(i), 8'($urandom));
        em = exp_rd(3'd4, 32'h110); ei = le_bytes(4, 32'h100);
        md_exp = exp_lat(1'b0, 3'd4, 32'h110);
        @(negedge clk);
        re_m = 1'b1; rvalid_bit = 3'd4; raddr_m = 32'h110; if_req = 1'b1; if_addr = 32'h100;
        c = 0; md = -1; id = -1; rdm = '0; rdi = '0;
        #1 sb = (stall_req !== 1'b1);
        while (c < 40 && id < 0) begin
            @(posedge clk); #1;
            c++;
            if (mem_done === 1'b1 && md < 0) begin
                md = c; rdm = rdata_m; re_m = 1'b0;
                sb |= (stall_req !== 1'b0);
            end else if (md < 0) sb |= (stall_req !== 1'b1);
            if (if_done === 1'b1) begin id = c; rdi = if_rdata; if_req = 1'b0; end
        end
        @(posedge clk); #1;
        n_chk++; if (md !== md_exp) begin n_fail++; $display("FAIL arb_mem_cycle: got %0d required %0d", md, md_exp); end
        // one IDLE re-arbitration cycle, then a five-cycle fetch and its DONE
        n_chk++; if (id !== md_exp + 7) begin n_fail++; $display("FAIL arb_if_cycle: got %0d required %0d", id, md_exp + 7); end
        n_chk++; if (rdm !== em) begin n_fail++; $display("FAIL arb_mem_data: got %h required %h", rdm, em); end
        n_chk++; if (rdi !== ei) begin n_fail++; $display("FAIL arb_if_data: got %h required %h", rdi, ei); end
        n_chk++; if (sb !== 1'b0) begin n_fail++; $display("FAIL arb_stall: stall_req profile wrong"); end
    endtask

    task automatic test_back_to_back;
        int c, md, id; logic [31:0] rdi, ei;
        ei = le_bytes(4, 32'h104);
        @(negedge clk);
        if_req = 1'b1; if_addr = 32'h104;
        c = 0; md = -1; id = -1; rdi = '0;
        while (c < 40 && md < 0) begin
            @(posedge clk); #1;
            c++;
            if (c == 2) begin we_m = 1'b1; wvalid_bit = 3'd1; waddr_m = 32'h120; wdata_m = 32'h0000005A; end
            if (if_done === 1'b1 && id < 0) begin id = c; rdi = if_rdata; if_req = 1'b0; end
            if (mem_done === 1'b1) begin md = c; we_m = 1'b0; end
        end
        @(posedge clk); #1;
        model_write(3'd1, 32'h120, 32'h0000005A);
        n_chk++; if (id !== 6) begin n_fail++; $display("FAIL b2b_if_cycle: got %0d required 6", id); end
        n_chk++; if (md !== 9) begin n_fail++; $display("FAIL b2b_mem_cycle: got %0d required 9", md); end
        n_chk++; if (rdi !== ei) begin n_fail++; $display("FAIL b2b_if_data: got %h required %h", rdi, ei); end
        n_chk++; if (ram_at(32'h120) !== rb(32'h120)) begin n_fail++; $display("FAIL b2b_byte: got %h required %h", ram_at(32'h120), rb(32'h120)); end
    endtask

    task automatic test_reset_mid;
        int w0, w1;
        @(negedge clk);
        we_m = 1'b1; wvalid_bit = 3'd4; waddr_m = 32'h300; wdata_m = 32'hA1B2C3D4;
        w0 = wr_cnt;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0; we_m = 1'b0;
        @(posedge clk); #1;
        for (int i = 0; i < 3; i++) ref_mem[32'h300 + 32'(i)] = wdata_m[8*i +: 8];
        w1 = wr_cnt;
        n_chk++;
        if ({ram_wr, ram_addr, ram_dout, if_rdata, rdata_m, if_done, mem_done, stall_req, mis_sig} !== '0) begin
            n_fail++;
            $display("FAIL rstmid_outputs: got wr=%b addr=%h dout=%h rd=%h md=%b st=%b required all zero",
                     ram_wr, ram_addr, ram_dout, rdata_m, mem_done, stall_req);
        end
        n_chk++; if (w1 - w0 !== 3) begin n_fail++; $display("FAIL rstmid_writes: got %0d required 3", w1 - w0); end
        repeat (3) @(posedge clk);
        #1;
        n_chk++; if (wr_cnt !== w1) begin n_fail++; $display("FAIL rstmid_late_write: got %0d writes after reset required 0", wr_cnt - w1); end
        n_chk++; if (ram_word(32'h300) !== le_bytes(4, 32'h300)) begin n_fail++; $display("FAIL rstmid_bytes: got %h required %h", ram_word(32'h300), le_bytes(4, 32'h300)); end
        @(negedge clk); rst = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_wrap;
        int lat, w0, el; logic [31:0] d, e, wd; logic mis, sb;
        preload(32'hFFFFFFFF, 8'h5A);
        preload(32'h00000000, 8'hEE);
        e = exp_rd(3'd1, 32'hFFFFFFFF);
        do_mem(1'b0, 1'b1, 3'd1, 32'hFFFFFFFF, 32'h0, lat, d, mis, sb);
        n_chk++; if (lat !== 3) begin n_fail++; $display("FAIL lb_wrap_latency: got %0d required 3", lat); end
        n_chk++; if (d !== e) begin n_fail++; $display("FAIL lb_wrap_data: got %h required %h", d, e); end
        wd = $urandom; w0 = wr_cnt; el = exp_lat(1'b1, 3'd4, 32'hFFFFFFFE);
        do_mem(1'b1, 1'b0, 3'd4, 32'hFFFFFFFE, wd, lat, d, mis, sb);
        model_write(3'd4, 32'hFFFFFFFE, wd);
        n_chk++; if (lat !== el) begin n_fail++; $display("FAIL sw_wrap_latency: got %0d required %0d", lat, el); end
        n_chk++; if (ram_word(32'hFFFFFFFE) !== le_bytes(4, 32'hFFFFFFFE)) begin n_fail++; $display("FAIL sw_wrap_bytes: got %h required %h", ram_word(32'hFFFFFFFE), le_bytes(4, 32'hFFFFFFFE)); end
    endtask

    task automatic test_invalid;
        int lat, w0; logic [31:0] d; logic mis, sb;
        logic [2:0] bad_n [5] = '{3'd0, 3'd3, 3'd5, 3'd6, 3'd7};
        for (int i = 0; i < 5; i++) begin
            do_mem(1'b0, 1'b1, 3'd4, 32'h100, 32'h0, lat, d, mis, sb);
            do_mem(1'b0, 1'b1, bad_n[i], 32'h100, 32'h0, lat, d, mis, sb);
            n_chk++; if (lat !== 1 || d !== 32'h0) begin n_fail++; $display("FAIL invalid_read[%0d]: got lat=%0d data=%h required lat=1 data=0", bad_n[i], lat, d); end
            w0 = wr_cnt;
            do_mem(1'b1, 1'b0, bad_n[i], 32'h100, $urandom, lat, d, mis, sb);
            n_chk++; if (lat !== 1 || wr_cnt !== w0) begin n_fail++; $display("FAIL invalid_write[%0d]: got lat=%0d writes=%0d required lat=1 writes=0", bad_n[i], lat, wr_cnt - w0); end
        end
    endtask

    task automatic test_misalign;
        int lat, w0, el; logic [31:0] d, e; logic mis, sb;
        e = exp_rd(3'd4, 32'h101); el = exp_lat(1'b0, 3'd4, 32'h101);
        do_mem(1'b0, 1'b1, 3'd4, 32'h101, 32'h0, lat, d, mis, sb);
        n_chk++; if (lat !== el || d !== e) begin n_fail++; $display("FAIL lw_101: got lat=%0d data=%h required lat=%0d data=%h", lat, d, el, e); end
`ifdef MEM_CTRL_ALIGN_CHK_EN
        n_chk++; if (mis !== 1'b1) begin n_fail++; $display("FAIL lw_101_misalign: got %b required 1", mis); end
`endif
        w0 = wr_cnt; el = exp_lat(1'b1, 3'd2, 32'h103);
        do_mem(1'b1, 1'b0, 3'd2, 32'h103, 32'h0000BEEF, lat, d, mis, sb);
        model_write(3'd2, 32'h103, 32'h0000BEEF);
        n_chk++; if (lat !== el || ram_word(32'h102) !== le_bytes(4, 32'h102)) begin n_fail++; $display("FAIL sh_103: got lat=%0d ram=%h required lat=%0d ram=%h", lat, ram_word(32'h102), el, le_bytes(4, 32'h102)); end
`ifdef MEM_CTRL_ALIGN_CHK_EN
        n_chk++; if (mis !== 1'b1 || wr_cnt !== w0) begin n_fail++; $display("FAIL sh_103_misalign: got mis=%b writes=%0d required mis=1 writes=0", mis, wr_cnt - w0); end
`endif
    endtask

    task automatic test_random;
        int lat, w0, el, ew; logic [31:0] a, d, e, wd; logic [2:0] n; logic mis, sb, wr, rd;
        logic [2:0] sizes [3] = '{3'd1, 3'd2, 3'd4};
        for (int it = 0; it < 60; it++) begin
            a = ($urandom_range(0, 4) == 0) ? 32'hFFFFFFFC + 32'($urandom_range(0, 3)) : 32'h200 + 32'($urandom_range(0, 63));
            if ($urandom_range(0, 4) == 0) begin
                e = le_bytes(4, a);
                do_if(a, lat, d);
                n_chk++; if (lat !== 6 || d !== e) begin n_fail++; $display("FAIL rand_fetch[%0d]: got lat=%0d data=%h required lat=6 data=%h", it, lat, d, e); end
            end else begin
                n = ($urandom_range(0, 9) < 8) ? sizes[$urandom_range(0, 2)] : 3'($urandom_range(0, 7));
                case ($urandom_range(0, 2))
                    0: begin wr = 1'b0; rd = 1'b1; end
                    1: begin wr = 1'b1; rd = 1'b0; end
                    default: begin wr = 1'b1; rd = 1'b1; end
                endcase
                wd = $urandom; w0 = wr_cnt;
                el = exp_lat(wr, n, a); e = exp_rd(n, a);
                ew = (wr && m_valid(n) && !m_mis(n, a)) ? int'(n) : 0;
                do_mem(wr, rd, n, a, wd, lat, d, mis, sb);
                if (wr) model_write(n, a, wd);
                n_chk++; if (lat !== el) begin n_fail++; $display("FAIL rand_latency[%0d]: n=%0d addr=%h got %0d required %0d", it, n, a, lat, el); end
                n_chk++; if (wr_cnt - w0 !== ew) begin n_fail++; $display("FAIL rand_writes[%0d]: got %0d required %0d", it, wr_cnt - w0, ew); end
                n_chk++; if (ram_word(a) !== le_bytes(4, a)) begin n_fail++; $display("FAIL rand_ram[%0d]: addr=%h got %h required %h", it, a, ram_word(a), le_bytes(4, a)); end
                n_chk++; if (sb !== 1'b0) begin n_fail++; $display("FAIL rand_stall[%0d]: stall_req profile wrong", it); end
                if (!wr) begin
                    n_chk++; if (d !== e) begin n_fail++; $display("FAIL rand_rdata[%0d]: n=%0d addr=%h got %h required %h", it, n, a, d, e); end
                end
`ifdef MEM_CTRL_ALIGN_CHK_EN
                n_chk++; if (mis !== m_mis(n, a)) begin n_fail++; $display("FAIL rand_misalign[%0d]: got %b required %b", it, mis, m_mis(n, a)); end
`endif
            end
        end
    endtask

    initial begin
        test_reset;
        test_sw;
        test_lh;
        test_arbitration;
        test_back_to_back;
        test_reset_mid;
        test_wrap;
        test_invalid;
        test_misalign;
        test_random;
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1);
    end
endmodule

// File: doc/mem_ctrl.md
MEM_CTRL -- requirements
Module: mem_ctrl

Interface
REQ-001 SHALL have port: clk  in  1  sole clock; all state changes on rising edge.
REQ-002 SHALL have port: rst  in  1  synchronous reset, active-low (rst==0 resets on clk edge).
REQ-003 SHALL have port: if_req  in  1  instruction fetch request (word read), held until if_done.
REQ-004 SHALL have port: if_addr  in  32  fetch byte address.
REQ-005 SHALL have port: if_rdata  out  32  fetched word, valid while if_done=1.
REQ-006 SHALL have port: if_done  out  1  one-cycle completion pulse for fetch.
REQ-007 SHALL have ports: re_m/we_m  in  1  MEM-stage read/write enable, held until mem_done.
REQ-008 SHALL have ports: rvalid_bit/wvalid_bit  in  3  byte count: 1=byte, 2=half, 4=word.
REQ-009 SHALL have ports: raddr_m/waddr_m  in  32; wdata_m  in  32; rdata_m  out  32.
REQ-010 SHALL have port: mem_done  out  1  one-cycle completion pulse for MEM-stage access.
REQ-011 SHALL have port: stall_req  out  1  pipeline stall request.
REQ-012 SHALL have ports: ram_addr  out  32; ram_wr  out  1; ram_dout  out  8; ram_din  in  8 (byte RAM, read data 1 cycle after address).
REQ-013 SHALL have port (MEM_CTRL_ALIGN_CHK_EN only): mem_misalign  out  1  misaligned-access pulse.

Function
REQ-014 SHALL implement FSM states IDLE, IF_RD, MEM_RD, MEM_WR, DONE.
REQ-015 SHALL, in IDLE, grant MEM-stage (re_m or we_m) over if_req; re_m and we_m both high SHALL be treated as write.
REQ-016 SHALL serialise N-byte access with 3-bit byte counter k=0..N-1, ram_addr=base+k (32-bit wrap at 0xFFFFFFFF).
REQ-017 SHALL in MEM_WR drive ram_wr=1, ram_dout=wdata_m[8k+7:8k] for N cycles, then DONE.
REQ-018 SHALL in reads capture ram_din one cycle after address k into bits [8k+7:8k] (little-endian); unused upper bytes zero; latency N+1 cycles from grant to DONE.
REQ-019 SHALL in DONE pulse if_done or mem_done for exactly one cycle with if_rdata/rdata_m stable, then return to IDLE.
REQ-020 SHALL hold stall_req=1 from any pending MEM request or granted access until DONE cycle, where stall_req=0.
REQ-021 SHALL re-arbitrate only in IDLE; MEM request arriving during IF_RD waits until IF completes.
REQ-022 SHALL keep ram_wr=0 in every state except MEM_WR.
REQ-023 SHALL ignore invalid byte counts (0,3,5-7): immediate DONE, rdata_m=0, no RAM write.

Reset
REQ-024 SHALL on rst==0: state=IDLE, k=0, ram_wr=0, ram_addr=0, ram_dout=0, if_rdata=0, rdata_m=0, if_done=0, mem_done=0, stall_req=0, mem_misalign=0.
REQ-025 SHALL abort any access mid-operation on reset; no further RAM write after reset edge.

Configuration
REQ-026 SHALL with MEM_CTRL_ALIGN_CHK_EN defined: half at odd address or word at address[1:0]!=0 -> no RAM access, mem_done and mem_misalign pulse in same cycle, rdata_m=0.
REQ-027 SHALL without MEM_CTRL_ALIGN_CHK_EN: misaligned accesses performed bytewise as aligned; port mem_misalign absent.

Structure
REQ-028 SHALL place state encodings, byte-count codes (Byte/Half/Word) and RAM width constants in shared defs package.
REQ-029 SHALL be single module; no sub-module needed.

Verification
REQ-030 SHALL cover: MEM SW addr 0x100 data 0x11223344 -> RAM bytes 0x44,0x33,0x22,0x11 at 0x100..0x103, mem_done at cycle 5.
REQ-031 SHALL cover: MEM LH addr 0x102 after ram 0x102=0x80,0x103=0xFF -> rdata_m=0x0000FF80, done at cycle 4.
REQ-032 SHALL cover: if_req and re_m same cycle -> MEM served first, IF completes after, stall_req low only on MEM DONE cycle.
REQ-033 SHALL cover: rst=0 at byte 2 of SW -> ram_wr=0 next cycle, state IDLE, all outputs zero.
REQ-034 SHALL cover: MEM_CTRL_ALIGN_CHK_EN, LW at 0x101 -> mem_misalign=1, no ram access, rdata_m=0.
REQ-035 SHALL cover: LB at 0xFFFFFFFF -> single access at 0xFFFFFFFF.
